// File: rtl/lif_spike_rate_display.sv
// ---------------------------------------------------------------------------
// lif_spike_rate_display
//   Counts rising edges of a LIF neuron spike output over a fixed window of
//   enabled clock cycles. At the end of each window the count is latched as a
//   saturated rate, a one-cycle valid strobe is raised, and a window-tick dot
//   is lit for DOT_CYCLES enabled cycles. One hex nibble of the rate drives
//   an active-high 7-segment display.
//
// Ports
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   ena         in   1        design enable; low freezes all counting state
//   spike_in    in   1        neuron spike (level, may stay high many cycles)
//   nibble_sel  in   1        0: show rate[3:0], 1: show rate[7:4]
//   seg_out     out  7        segments {g,f,e,d,c,b,a}, active high
//   dot_out     out  1        window-tick decimal point
//   rate_out    out  COUNT_W  spike count of the last completed window
//   rate_valid  out  1        one-cycle pulse when rate_out updates
// ---------------------------------------------------------------------------
module lif_spike_rate_display #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int COUNT_W       = 8,
  parameter int DOT_CYCLES    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               spike_in,
  input  logic               nibble_sel,
  output logic [6:0]         seg_out,
  output logic               dot_out,
  output logic [COUNT_W-1:0] rate_out,
  output logic               rate_valid
);

  localparam int TIMER_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int DOT_W   = $clog2(DOT_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [DOT_W-1:0]   DOT_LOAD   = DOT_W'(DOT_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_MAX    = {COUNT_W{1'b1}};

  // Hex digit to active-high {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [TIMER_W-1:0] r_timer;
  logic [COUNT_W-1:0] r_cnt;
  logic [COUNT_W-1:0] r_rate;
  logic [DOT_W-1:0]   r_dot_cnt;
  logic               r_spike_d;
  logic               r_valid;
  logic               r_dot;
  logic [6:0]         r_seg;

  logic               w_edge;
  logic               w_terminal;
  logic [COUNT_W-1:0] w_cnt_inc;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [DOT_W-1:0]   w_dot_nxt;
  logic [7:0]         w_rate8;
  logic [3:0]         w_nibble;

  assign w_edge     = spike_in & ~r_spike_d;
  assign w_terminal = (r_timer == TIMER_LAST);

  // Next-state values for the counter, window timer and dot timer.
  always_comb begin
    w_cnt_inc   = r_cnt;
    w_timer_nxt = r_timer;
    w_dot_nxt   = r_dot_cnt;
    w_rate8     = 8'h00;
    w_nibble    = 4'h0;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    if (w_edge && (r_cnt != CNT_MAX)) begin
      w_cnt_inc = r_cnt + COUNT_W'(1'b1);
    end else begin
      w_cnt_inc = r_cnt;
    end

    if (w_terminal) begin
      w_timer_nxt = {TIMER_W{1'b0}};
      w_dot_nxt   = DOT_LOAD;
    end else begin
      w_timer_nxt = r_timer + TIMER_W'(1'b1);
      if (r_dot_cnt != {DOT_W{1'b0}}) begin
        w_dot_nxt = r_dot_cnt - DOT_W'(1'b1);
      end else begin
        w_dot_nxt = {DOT_W{1'b0}};
      end
    end

    // The display only ever sees the low byte; narrow rates are zero-extended.
    w_rate8 = 8'(r_rate);
    if (nibble_sel) begin
      w_nibble = w_rate8[7:4];
    end else begin
      w_nibble = w_rate8[3:0];
    end
  end

  // Window timing, spike counting, rate latch, valid strobe and dot timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= {TIMER_W{1'b0}};
      r_cnt     <= {COUNT_W{1'b0}};
      r_rate    <= {COUNT_W{1'b0}};
      r_dot_cnt <= {DOT_W{1'b0}};
      r_spike_d <= 1'b0;
      r_valid   <= 1'b0;
      r_dot     <= 1'b0;
    end else if (ena) begin
      r_spike_d <= spike_in;
      r_timer   <= w_timer_nxt;
      r_dot_cnt <= w_dot_nxt;
      r_dot     <= (w_dot_nxt != {DOT_W{1'b0}});
      r_valid   <= w_terminal;
      if (w_terminal) begin
        // An edge on the terminal cycle belongs to the closing window.
        r_rate <= w_cnt_inc;
        r_cnt  <= {COUNT_W{1'b0}};
      end else begin
        r_cnt  <= w_cnt_inc;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Display decode; runs regardless of ena so nibble_sel always takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 7'h3F;
    end else begin
      r_seg <= hex_to_seg(w_nibble);
    end
  end

  assign seg_out    = r_seg;
  assign dot_out    = r_dot;
  assign rate_out   = r_rate;
  assign rate_valid = r_valid;

endmodule

// File: tb/tb_lif_spike_rate_display.sv
module tb_lif_spike_rate_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ena, spike_in, nibble_sel;

  logic [6:0] seg   [3];
  logic       dot   [3];
  logic [7:0] rate  [3];
  logic       valid [3];
  logic [3:0] rate2_w;

  assign rate[2] = {4'h0, rate2_w};

  // dut0: short window, 8-bit count
  lif_spike_rate_display #(.WINDOW_CYCLES(16), .COUNT_W(8), .DOT_CYCLES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .nibble_sel(nibble_sel),
    .seg_out(seg[0]), .dot_out(dot[0]), .rate_out(rate[0]), .rate_valid(valid[0]));

  // dut1: long window, able to reach 0xA5
  lif_spike_rate_display #(.WINDOW_CYCLES(400), .COUNT_W(8), .DOT_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .nibble_sel(nibble_sel),
    .seg_out(seg[1]), .dot_out(dot[1]), .rate_out(rate[1]), .rate_valid(valid[1]));

  // dut2: 4-bit count, window long enough to saturate when toggling
  lif_spike_rate_display #(.WINDOW_CYCLES(40), .COUNT_W(4), .DOT_CYCLES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .nibble_sel(nibble_sel),
    .seg_out(seg[2]), .dot_out(dot[2]), .rate_out(rate2_w), .rate_valid(valid[2]));

  localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int WIN [3] = '{16, 400, 40};
  int DOTC[3] = '{4, 4, 4};
  int MAXC[3] = '{255, 255, 15};

  // Reference model: position within window, raw (unsaturated) spike count.
  int         m_pos  [3];
  int         m_win  [3];
  int         m_rate [3];
  int         m_dot  [3];
  bit         m_valid[3];
  bit         m_prev [3];
  logic [6:0] m_seg  [3];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      m_pos[j] = 0; m_win[j] = 0; m_rate[j] = 0; m_dot[j] = 0;
      m_valid[j] = 1'b0; m_prev[j] = 1'b0; m_seg[j] = 7'h3F;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int j = 0; j < 3; j++) begin
        int byte_v;
        byte_v = m_rate[j] % 256;
        m_seg[j] = SEG_TBL[nibble_sel ? (byte_v / 16) : (byte_v % 16)];
        if (ena) begin
          if (spike_in && !m_prev[j]) m_win[j]++;
          m_prev[j] = spike_in;
          if (m_pos[j] == WIN[j] - 1) begin
            m_rate[j]  = (m_win[j] > MAXC[j]) ? MAXC[j] : m_win[j];
            m_win[j]   = 0;
            m_pos[j]   = 0;
            m_valid[j] = 1'b1;
            m_dot[j]   = DOTC[j];
          end else begin
            m_pos[j]++;
            m_valid[j] = 1'b0;
            if (m_dot[j] > 0) m_dot[j]--;
          end
        end else begin
          m_valid[j] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rate%0d", j),  32'(rate[j]),  32'(m_rate[j]));
      chk($sformatf("valid%0d", j), 32'(valid[j]), 32'(m_valid[j]));
      chk($sformatf("dot%0d", j),   32'(dot[j]),   32'(m_dot[j] != 0));
      chk($sformatf("seg%0d", j),   32'(seg[j]),   32'(m_seg[j]));
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n, input logic sp);
    spike_in = sp;
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; spike_in = 1'b0; nibble_sel = 1'b0;
    model_reset();
    @(negedge clk);
    step();
    compare_all();
    chk("reset_seg", 32'(seg[0]), 32'h3F);
    chk("reset_rate", 32'(rate[0]), 32'h0);
    rst_n = 1'b1;

    // Test 1: three single-cycle spikes in the first window
    for (int i = 1; i <= 16; i++) begin
      spike_in = (i == 2 || i == 5 || i == 8);
      step();
    end
    chk("t1_rate", 32'(rate[0]), 32'd3);
    chk("t1_valid_hi", 32'(valid[0]), 32'd1);
    chk("t1_dot_hi", 32'(dot[0]), 32'd1);

    // Test 2a: spike held high 10 cycles counts once
    spike_in = 1'b1;
    step();
    chk("t1_valid_lo", 32'(valid[0]), 32'd0);
    chk("t1_seg", 32'(seg[0]), 32'h4F);
    cycles(3, 1'b1);
    chk("t1_dot_lo", 32'(dot[0]), 32'd0);
    cycles(6, 1'b1);
    cycles(6, 1'b0);
    chk("t2_held_rate", 32'(rate[0]), 32'd1);

    // Test 2b: 1-0-1-0-1 counts three times
    cycles(1, 1'b1); cycles(1, 1'b0); cycles(1, 1'b1); cycles(1, 1'b0); cycles(1, 1'b1);
    cycles(11, 1'b0);
    chk("t2_alt_rate", 32'(rate[0]), 32'd3);

    // Test 4: edge on the terminal cycle lands in the closing window
    cycles(15, 1'b0);
    cycles(1, 1'b1);
    chk("t4_term_rate", 32'(rate[0]), 32'd1);
    cycles(16, 1'b0);
    chk("t4_next_rate", 32'(rate[0]), 32'd0);

    // Test 5: 20 disabled cycles with toggling spikes mid-window
    cycles(5, 1'b0);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      spike_in = (i % 2 == 0);
      step();
    end
    ena = 1'b1;
    cycles(1, 1'b1); cycles(1, 1'b0); cycles(1, 1'b1); cycles(7, 1'b0);
    chk("t5_not_yet", 32'(valid[0]), 32'd0);
    cycles(1, 1'b0);
    chk("t5_late_valid", 32'(valid[0]), 32'd1);
    chk("t5_rate", 32'(rate[0]), 32'd2);

    // Test 3: continuous toggling saturates the 4-bit build
    for (int i = 0; i < 120; i++) begin
      spike_in = ~spike_in;
      step();
    end
    cycles(3, 1'b0);
    chk("t3_rate_sat", 32'(rate[2]), 32'd15);
    chk("t3_seg_F", 32'(seg[2]), 32'h71);

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      spike_in   = 1'($urandom_range(0, 1));
      ena        = ($urandom_range(0, 9) != 0);
      nibble_sel = 1'($urandom_range(0, 1));
      step();
    end
    ena = 1'b1; nibble_sel = 1'b0; spike_in = 1'b0;

    // Test 6: reach 0xA5 in the long window, then switch nibbles
    async_reset();
    for (int i = 0; i < 165; i++) begin
      cycles(1, 1'b1);
      cycles(1, 1'b0);
    end
    cycles(70, 1'b0);
    chk("t6_rate_a5", 32'(rate[1]), 32'hA5);
    chk("t6_valid", 32'(valid[1]), 32'd1);
    step();
    chk("t6_seg_lo", 32'(seg[1]), 32'h6D);
    nibble_sel = 1'b1;
    step();
    chk("t6_seg_hi", 32'(seg[1]), 32'h77);
    cycles(5, 1'b1);
    async_reset();
    chk("t6_rst_seg", 32'(seg[1]), 32'h3F);
    cycles(4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
